// File: rtl/keypad_time_entry_pkg.sv
// rtl/keypad_time_entry_pkg.sv - key codes, entry FSM states and HHMM validation helper
package keypad_time_entry_pkg;

  localparam int KEY_W = 5;
  typedef logic [KEY_W-1:0] key_t;

  localparam key_t KEY_STAR = 5'd10;
  localparam key_t KEY_HASH = 5'd11;
  localparam key_t KEY_A    = 5'd12;
  localparam key_t KEY_B    = 5'd13;
  localparam key_t KEY_C    = 5'd14;
  localparam key_t KEY_D    = 5'd15;
  localparam key_t KEY_NONE = 5'd16;

  typedef enum logic [1:0] {ST_IDLE, ST_ENTRY, ST_FULL} entry_state_t;

  function automatic key_t key_at(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'h0:    return 5'd1;
      4'h1:    return 5'd2;
      4'h2:    return 5'd3;
      4'h3:    return KEY_A;
      4'h4:    return 5'd4;
      4'h5:    return 5'd5;
      4'h6:    return 5'd6;
      4'h7:    return KEY_B;
      4'h8:    return 5'd7;
      4'h9:    return 5'd8;
      4'hA:    return 5'd9;
      4'hB:    return KEY_C;
      4'hC:    return KEY_STAR;
      4'hD:    return 5'd0;
      4'hE:    return KEY_HASH;
      default: return KEY_D;
    endcase
  endfunction

  // 24-hour HHMM in BCD; the nibble bounds also reject non-BCD digits
  function automatic logic valid_time(input logic [15:0] t);
    logic hh_ok, mm_ok;
    hh_ok = (t[15:12] < 4'd2 && t[11:8] <= 4'd9) || (t[15:12] == 4'd2 && t[11:8] <= 4'd3);
    mm_ok = (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    return hh_ok && mm_ok;
  endfunction

endpackage

// File: rtl/keypad_time_entry_if.sv
// rtl/keypad_time_entry_if.sv - debounced key event from scanner to entry FSM
interface keypad_time_entry_if;
  import keypad_time_entry_pkg::*;

  logic press;
  key_t key;

  modport master (output press, key);
  modport slave  (input press, key);
endinterface

// File: rtl/keypad_time_entry_scanner.sv
// rtl/keypad_time_entry_scanner.sv - column scan, single-key decode, debounce and press event
module keypad_time_entry_scanner
  import keypad_time_entry_pkg::*;
#(
  parameter int CLK_IN         = 5000000,
  parameter int SCAN_RATE      = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  keypad_time_entry_if.master evt
);

  localparam int STEP_DIV = CLK_IN / SCAN_RATE;
  localparam int STEP_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int RUN_W    = $clog2(DEBOUNCE_SCANS + 1);

  logic [STEP_W-1:0] step_cnt;
  logic              tick;
  logic [1:0]        col, hits, hits_next;
  logic [2:0]        col_lows, hit_sum;
  key_t              col_key, acc_key, key_next, scan_key, cand, stable, key_r;
  logic              scan_done, armed, accept, press;
  logic [RUN_W-1:0]  run_cnt, run_next;

  assign tick     = (step_cnt == STEP_W'(STEP_DIV - 1));
  assign cols     = ~(4'b0001 << col);
  assign evt.press = press;
  assign evt.key   = key_r;

  // hits saturates at 2: anything other than exactly one intersection decodes to NONE
  always_comb begin
    col_lows = '0;
    col_key  = KEY_NONE;
    for (int r = 3; r >= 0; r--) begin
      if (!rows[r]) begin
        col_lows = col_lows + 3'd1;
        col_key  = key_at(2'(r), col);
      end
    end
    hit_sum   = {1'b0, hits} + col_lows;
    hits_next = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
    key_next  = (col_lows != 3'd0) ? col_key : acc_key;
    if (scan_key == cand)
      run_next = (run_cnt == RUN_W'(DEBOUNCE_SCANS)) ? run_cnt : run_cnt + RUN_W'(1);
    else
      run_next = RUN_W'(1);
    accept = scan_done && (run_next == RUN_W'(DEBOUNCE_SCANS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt  <= '0;
      col       <= 2'd0;
      hits      <= 2'd0;
      acc_key   <= KEY_NONE;
      scan_key  <= KEY_NONE;
      scan_done <= 1'b0;
      cand      <= KEY_NONE;
      run_cnt   <= '0;
      stable    <= KEY_NONE;
      armed     <= 1'b0;
      press     <= 1'b0;
      key_r     <= KEY_NONE;
    end else begin
      scan_done <= 1'b0;
      press     <= 1'b0;
      if (tick) begin
        step_cnt <= '0;
        col      <= col + 2'd1;
        if (col == 2'd3) begin
          scan_key  <= (hits_next == 2'd1) ? key_next : KEY_NONE;
          scan_done <= 1'b1;
          hits      <= 2'd0;
          acc_key   <= KEY_NONE;
        end else begin
          hits    <= hits_next;
          acc_key <= key_next;
        end
      end else begin
        step_cnt <= step_cnt + STEP_W'(1);
      end
      if (scan_done) begin
        cand    <= scan_key;
        run_cnt <= run_next;
      end
      // armed only after a stable release, so a key held through reset stays silent
      if (accept) begin
        if (scan_key == KEY_NONE)
          armed <= 1'b1;
        if (scan_key != stable) begin
          stable <= scan_key;
          key_r  <= scan_key;
          press  <= armed && (stable == KEY_NONE) && (scan_key != KEY_NONE);
        end
      end
    end
  end

endmodule

// File: rtl/keypad_time_entry.sv
// rtl/keypad_time_entry.sv - keypad HHMM entry: digit shift register, '*' clear, '#' validate and load
module keypad_time_entry
  import keypad_time_entry_pkg::*;
#(
  parameter int CLK_IN         = 5000000,
  parameter int SCAN_RATE      = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [3:0]  i_Rows,
  output logic [3:0]  o_Cols,
  output logic [15:0] o_Entry,
  output logic [2:0]  o_Digit_Count,
  output logic [15:0] o_Time,
  output logic        o_Time_Valid,
  output logic        o_Error
);

  keypad_time_entry_if key_evt ();
  entry_state_t state;

  keypad_time_entry_scanner #(
    .CLK_IN         (CLK_IN),
    .SCAN_RATE      (SCAN_RATE),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scanner (
    .clk  (i_Clk),
    .rst  (i_Reset),
    .rows (i_Rows),
    .cols (o_Cols),
    .evt  (key_evt)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state         <= ST_IDLE;
      o_Entry       <= '0;
      o_Digit_Count <= '0;
      o_Time        <= '0;
      o_Time_Valid  <= 1'b0;
      o_Error       <= 1'b0;
    end else begin
      o_Time_Valid <= 1'b0;
      o_Error      <= 1'b0;
      if (key_evt.press) begin
        if (key_evt.key <= 5'd9) begin
          if (state != ST_FULL) begin
            o_Entry       <= {o_Entry[11:0], key_evt.key[3:0]};
            o_Digit_Count <= o_Digit_Count + 3'd1;
            state         <= (o_Digit_Count == 3'd3) ? ST_FULL : ST_ENTRY;
          end
        end else if (key_evt.key == KEY_STAR) begin
          o_Entry       <= '0;
          o_Digit_Count <= '0;
          state         <= ST_IDLE;
        end else if (key_evt.key == KEY_HASH) begin
          if (state == ST_FULL && valid_time(o_Entry)) begin
            o_Time       <= o_Entry;
            o_Time_Valid <= 1'b1;
          end else begin
            o_Error <= 1'b1;
          end
          o_Entry       <= '0;
          o_Digit_Count <= '0;
          state         <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_time_entry.sv
// tb/tb_keypad_time_entry.sv - keypad model driving rows from columns, scoreboard of entry/time events
module tb_keypad_time_entry;
  import keypad_time_entry_pkg::*;

  typedef struct {
    logic [15:0] entry;
    logic [2:0]  count;
    logic [15:0] tim;
    logic        tv;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rows, cols;
  logic [15:0] entry, time_out;
  logic [2:0]  count;
  logic        tv, err;
  logic [15:0] held = '0;

  int compared = 0, mismatched = 0;
  int tv_pulses = 0, err_pulses = 0;
  exp_t sb[$];
  logic [15:0] m_entry = '0, m_time = '0;
  int m_cnt = 0;
  string layout = "123A456B789C*0#D";

  always #5 clk = ~clk;

  keypad_time_entry #(.CLK_IN(1000), .SCAN_RATE(100), .DEBOUNCE_SCANS(2)) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_Rows        (rows),
    .o_Cols        (cols),
    .o_Entry       (entry),
    .o_Digit_Count (count),
    .o_Time        (time_out),
    .o_Time_Valid  (tv),
    .o_Error       (err)
  );

  keypad_time_entry_if probe ();
  assign probe.press = dut.key_evt.press;
  assign probe.key   = dut.key_evt.key;

  // a held key pulls its row low while its column is driven low
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int pos_of(input byte ch);
    for (int i = 0; i < 16; i++)
      if (layout[i] == ch) return i;
    return 0;
  endfunction

  function automatic bit time_ok(input logic [15:0] t);
    int hh, mm;
    if (t[15:12] > 9 || t[11:8] > 9 || t[7:4] > 9 || t[3:0] > 9) return 1'b0;
    hh = int'(t[15:12]) * 10 + int'(t[11:8]);
    mm = int'(t[7:4]) * 10 + int'(t[3:0]);
    return (hh <= 23) && (mm <= 59);
  endfunction

  task automatic tap(input byte ch);
    held = '0;
    held[pos_of(ch)] = 1'b1;
    wait_cycles(160);
    held = '0;
    wait_cycles(160);
  endtask

  task automatic press_ch(input byte ch);
    bit push, p_tv, p_err;
    push = 0; p_tv = 0; p_err = 0;
    if (ch >= "0" && ch <= "9") begin
      if (m_cnt < 4) begin
        m_entry = {m_entry[11:0], 4'(ch - "0")};
        m_cnt++;
        push = 1;
      end
    end else if (ch == "*") begin
      push = (m_cnt != 0);
      m_entry = '0;
      m_cnt = 0;
    end else if (ch == "#") begin
      if (m_cnt == 4 && time_ok(m_entry)) begin
        m_time = m_entry;
        p_tv = 1;
      end else begin
        p_err = 1;
      end
      m_entry = '0;
      m_cnt = 0;
      push = 1;
    end
    if (push) sb.push_back('{m_entry, 3'(m_cnt), m_time, p_tv, p_err});
    tap(ch);
  endtask

  task automatic press_seq(input string s);
    for (int i = 0; i < s.len(); i++) press_ch(s[i]);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cols"},  32'(cols),     32'hE);
    check({tag, "_entry"}, 32'(entry),    32'h0);
    check({tag, "_count"}, 32'(count),    32'h0);
    check({tag, "_time"},  32'(time_out), 32'h0);
    check({tag, "_tv"},    32'(tv),       32'h0);
    check({tag, "_err"},   32'(err),      32'h0);
  endtask

  // monitor: every visible output change or pulse consumes one scoreboard entry
  initial begin
    logic [15:0] prev_entry;
    logic [2:0]  prev_cnt;
    bit          hash_prev;
    exp_t        e;
    prev_entry = '0;
    prev_cnt   = '0;
    hash_prev  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_entry = entry;
        prev_cnt   = count;
        hash_prev  = 0;
      end else begin
        if (tv) tv_pulses++;
        if (err) err_pulses++;
        if (hash_prev) begin
          check("hash_latency", 32'(tv | err), 32'd1);
          check("pulse_exclusive", 32'(tv & err), 32'd0);
        end
        hash_prev = probe.press && (probe.key == KEY_HASH);
        if (entry !== prev_entry || count !== prev_cnt || tv || err) begin
          compared++;
          assert (sb.size() > 0) else begin
            mismatched++;
            $error("FAIL unexpected_event: observed entry=%h count=%0d tv=%b err=%b, required no event",
                   entry, count, tv, err);
          end
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_entry", 32'(entry),    32'(e.entry));
            check("sb_count", 32'(count),    32'(e.count));
            check("sb_time",  32'(time_out), 32'(e.tim));
            check("sb_tv",    32'(tv),       32'(e.tv));
            check("sb_err",   32'(err),      32'(e.err));
          end
        end
        prev_entry = entry;
        prev_cnt   = count;
      end
    end
  end

  initial begin
    rst = 1'b1;
    wait_cycles(4);
    check_reset_values("reset");
    rst = 1'b0;
    wait_cycles(160);

    press_seq("1230#");
    check("time_1230", 32'(time_out), 32'h1230);
    check("tv_once", 32'(tv_pulses), 32'd1);

    press_seq("2400#");
    check("time_kept_2400", 32'(time_out), 32'h1230);
    check("err_2400", 32'(err_pulses), 32'd1);
    press_seq("1260#");
    check("err_1260", 32'(err_pulses), 32'd2);

    press_seq("12#");
    check("short_count", 32'(count), 32'd0);
    check("err_short", 32'(err_pulses), 32'd3);
    press_seq("12*#");
    check("err_star_hash", 32'(err_pulses), 32'd4);
    check("tv_unchanged", 32'(tv_pulses), 32'd1);

    press_seq("09457#");
    check("time_0945", 32'(time_out), 32'h0945);
    check("tv_second", 32'(tv_pulses), 32'd2);

    held = '0;
    held[pos_of("5")] = 1'b1;
    held[pos_of("8")] = 1'b1;
    wait_cycles(200);
    held = '0;
    wait_cycles(200);
    held[pos_of("5")] = 1'b1;
    wait_cycles(40);
    held = '0;
    wait_cycles(200);
    check("no_event_multi_bounce", 32'(count), 32'd0);
    press_seq("A5D");
    check("single_5", 32'(entry), 32'h0005);
    press_seq("*");

    press_seq("12");
    check("sb_drained_pre_reset", 32'(sb.size()), 32'd0);
    held = '0;
    held[pos_of("3")] = 1'b1;
    wait_cycles(30);
    rst = 1'b1;
    wait_cycles(3);
    check_reset_values("mid_reset");
    m_entry = '0;
    m_cnt = 0;
    m_time = '0;
    rst = 1'b0;
    wait_cycles(200);
    check("held_through_reset", 32'(count), 32'd0);
    held = '0;
    wait_cycles(160);
    press_seq("3");
    check("after_release_3", 32'(entry), 32'h0003);
    check("after_release_cnt", 32'(count), 32'd1);

    check("sb_drained_end", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
